sr_decode_stage: RTL and testbench

//  Registered RV32I decode stage with valid/ready handshake, between fetch and execute in schoolRISCV.

---
 rtl/sr_decode_stage_pkg.sv | 32 +++
 rtl/sr_imm_gen.sv | 22 ++
 rtl/sr_decode_stage.sv | 82 ++++++++
 tb/tb_sr_decode_stage.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sr_decode_stage_pkg.sv
// sr_decode_stage_pkg: instruction format codes, RV32I opcodes and opcode-to-format lookup.
package sr_decode_stage_pkg;
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  function automatic logic [2:0] op_fmt(input logic [6:0] op);
    return op == OP_REG ? FMT_R :
           (op == OP_IMM || op == OP_LOAD || op == OP_JALR ||
            op == OP_SYSTEM || op == OP_FENCE) ? FMT_I :
           op == OP_STORE ? FMT_S :
           op == OP_BRANCH ? FMT_B :
           (op == OP_LUI || op == OP_AUIPC) ? FMT_U :
           op == OP_JAL ? FMT_J : FMT_NONE;
  endfunction
endpackage

// File: rtl/sr_imm_gen.sv
// sr_imm_gen: combinational format classification and sign-extended immediate selection.
module sr_imm_gen
  import sr_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm
);
  logic [31:0] imm32;
  always_comb begin
    fmt = op_fmt(instr[6:0]);
    imm32 = fmt == FMT_I ? {{20{instr[31]}}, instr[31:20]} :
            fmt == FMT_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            fmt == FMT_B ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
            fmt == FMT_U ? {instr[31:12], 12'b0} :
            fmt == FMT_J ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
            32'd0;
    imm = XLEN'($signed(imm32));
  end
endmodule

// File: rtl/sr_decode_stage.sv
// sr_decode_stage: registered RV32I decode with 2-entry skid buffer and flush.
// Optional SR_DECODE_ILLEGAL_EN carries an illegal-instruction flag with each entry.
module sr_decode_stage
  import sr_decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_f3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_f7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);
`ifdef SR_DECODE_ILLEGAL_EN
  localparam int EW = XLEN + PC_W + 36;
`else
  localparam int EW = XLEN + PC_W + 35;
`endif
  logic [2:0] fmt;
  logic [XLEN-1:0] imm;
  logic [EW-1:0] in_e, head, skid;
  logic hv, sv, rdy, push;
  sr_imm_gen #(.XLEN(XLEN)) u_imm (.instr(in_instr), .fmt(fmt), .imm(imm));
  // Entry layout: {[illegal,] pc, imm, fmt, instr}
`ifdef SR_DECODE_ILLEGAL_EN
  assign in_e = {fmt == FMT_NONE || in_instr[1:0] != 2'b11, in_pc, imm, fmt, in_instr};
  assign out_illegal = head[EW-1];
`else
  assign in_e = {in_pc, imm, fmt, in_instr};
  assign out_illegal = 1'b0;
`endif
  assign push = in_valid & rdy;
  assign in_ready = rdy;
  assign out_valid = hv;
  assign out_op = head[6:0];
  assign out_rd = head[11:7];
  assign out_f3 = head[14:12];
  assign out_rs1 = head[19:15];
  assign out_rs2 = head[24:20];
  assign out_f7 = head[31:25];
  assign out_fmt = head[34:32];
  assign out_imm = head[35 +: XLEN];
  assign out_pc = head[35+XLEN +: PC_W];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hv <= 1'b0;
      sv <= 1'b0;
      rdy <= 1'b1;
      head <= '0;
      skid <= '0;
    end else if (flush) begin
      hv <= 1'b0;
      sv <= 1'b0;
      rdy <= 1'b1;
    end else if (!hv || out_ready) begin
      hv <= sv || push;
      sv <= 1'b0;
      rdy <= 1'b1;
      if (sv) head <= skid;
      else if (push) head <= in_e;
    end else if (push) begin
      skid <= in_e;
      sv <= 1'b1;
      rdy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sr_decode_stage.sv
// tb_sr_decode_stage: directed checks of decode, skid buffering, flush, XLEN=64 sign extension.
module tb_sr_decode_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic in_ready, out_valid, out_illegal;
  logic [6:0] out_op, out_f7;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [2:0] out_f3, out_fmt;
  logic [31:0] out_imm, out_pc;
  logic w_in_ready, w_out_valid, w_out_illegal;
  logic [6:0] w_out_op, w_out_f7;
  logic [4:0] w_out_rd, w_out_rs1, w_out_rs2;
  logic [2:0] w_out_f3, w_out_fmt;
  logic [63:0] w_out_imm;
  logic [31:0] w_out_pc;
  int total = 0, bad = 0;
  logic exp_ill;
  always #5 clk = ~clk;
  sr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_f3(out_f3), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_f7(out_f7), .out_fmt(out_fmt), .out_imm(out_imm), .out_pc(out_pc),
    .out_illegal(out_illegal)
  );
  sr_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_op(w_out_op), .out_rd(w_out_rd), .out_f3(w_out_f3), .out_rs1(w_out_rs1),
    .out_rs2(w_out_rs2), .out_f7(w_out_f7), .out_fmt(w_out_fmt), .out_imm(w_out_imm),
    .out_pc(w_out_pc), .out_illegal(w_out_illegal)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc = pc;
  endtask
  initial begin
`ifdef SR_DECODE_ILLEGAL_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc", out_pc, 0);
    rst_n = 1'b1;
    drive(1, 32'hFFF00093, 32'h100);
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_fmt", out_fmt, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_ill", out_illegal, 0);
    chk("addi_imm64", w_out_imm, 64'hFFFFFFFFFFFFFFFF);
    drive(1, 32'hFE112E23, 32'h104);
    tick();
    chk("sw_fmt", out_fmt, 2);
    chk("sw_rs1", out_rs1, 2);
    chk("sw_rs2", out_rs2, 1);
    chk("sw_imm", out_imm, 32'hFFFFFFFC);
    drive(1, 32'hFE000CE3, 32'h108);
    tick();
    chk("beq_fmt", out_fmt, 3);
    chk("beq_imm", out_imm, 32'hFFFFFFF8);
    drive(1, 32'h123452B7, 32'h10C);
    tick();
    chk("lui_fmt", out_fmt, 4);
    chk("lui_rd", out_rd, 5);
    chk("lui_imm", out_imm, 32'h12345000);
    drive(1, 32'h001000EF, 32'h110);
    tick();
    chk("jal_fmt", out_fmt, 5);
    chk("jal_imm", out_imm, 32'h00000800);
    chk("jal_pc", out_pc, 32'h110);
    drive(0, 32'h0, 32'h0);
    tick();
    chk("drain_valid", out_valid, 0);
    out_ready = 1'b0;
    drive(1, 32'hFFF00093, 32'h200);
    tick();
    chk("stall_a_rdy", in_ready, 1);
    drive(1, 32'h123452B7, 32'h204);
    tick();
    chk("stall_b_rdy", in_ready, 0);
    chk("stall_b_head", out_pc, 32'h200);
    drive(1, 32'h001000EF, 32'h208);
    tick();
    chk("stall_c_rdy", in_ready, 0);
    chk("stall_c_head", out_pc, 32'h200);
    chk("stall_c_imm", out_imm, 32'hFFFFFFFF);
    out_ready = 1'b1;
    tick();
    chk("rel_b_pc", out_pc, 32'h204);
    chk("rel_b_fmt", out_fmt, 4);
    chk("rel_b_rdy", in_ready, 1);
    tick();
    drive(0, 32'h0, 32'h0);
    chk("rel_c_pc", out_pc, 32'h208);
    chk("rel_c_fmt", out_fmt, 5);
    chk("rel_c_valid", out_valid, 1);
    tick();
    chk("rel_empty", out_valid, 0);
    out_ready = 1'b0;
    drive(1, 32'hFFF00093, 32'h300);
    tick();
    drive(1, 32'hFE112E23, 32'h304);
    tick();
    chk("fl_pre_rdy", in_ready, 0);
    flush = 1'b1;
    drive(1, 32'hFE000CE3, 32'h308);
    tick();
    flush = 1'b0;
    drive(0, 32'h0, 32'h0);
    chk("fl_valid", out_valid, 0);
    chk("fl_rdy", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("fl_after", out_valid, 0);
    drive(1, 32'h00000000, 32'h400);
    tick();
    drive(0, 32'h0, 32'h0);
    chk("none_valid", out_valid, 1);
    chk("none_fmt", out_fmt, 7);
    chk("none_imm", out_imm, 0);
    chk("none_ill", out_illegal, exp_ill);
    chk("none_imm64", w_out_imm, 0);
    chk("none_ill64", w_out_illegal, exp_ill);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
